// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : aes_word_packer
// Description : Word/block adapter in front of the AES core.
//               Pack side: pops NWORDS words from an upstream FWFT FIFO and
//               presents them as one WORD_W*NWORDS block, first word in the
//               least significant slot.
//               Unpack side: captures one core result and pushes it to the
//               readout FIFO one word at a time, lowest word first.
//               The two sides are independent and run concurrently.
// Ports       : clk_main_a0    - clock, all logic on its rising edge
//               rst_main_sync  - synchronous active-high reset
//               in_empty/in_dout/in_rd_en       - upstream FWFT FIFO
//               blk_valid/blk_data/blk_ready    - block towards the core
//               res_valid/res_data/res_ready    - result from the core
//               out_full/out_wr_en/out_din      - readout FIFO
//               blk_count/res_count             - wrapping block counters
//               busy                            - pack or unpack in progress
// Revision    : 1.0 - initial release
// ============================================================================
module aes_word_packer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                       clk_main_a0,
  input  logic                       rst_main_sync,
  input  logic                       in_empty,
  input  logic [WORD_W-1:0]          in_dout,
  output logic                       in_rd_en,
  output logic                       blk_valid,
  output logic [WORD_W*NWORDS-1:0]   blk_data,
  input  logic                       blk_ready,
  input  logic                       res_valid,
  input  logic [WORD_W*NWORDS-1:0]   res_data,
  output logic                       res_ready,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic [WORD_W-1:0]          out_din,
  output logic [31:0]                blk_count,
  output logic [31:0]                res_count,
  output logic                       busy
);

  localparam int c_blk_w = WORD_W * NWORDS;
  localparam int c_idx_w = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NWORDS - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  typedef enum logic [0:0] {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } pk_state_t;

  typedef enum logic [0:0] {
    UN_IDLE  = 1'b0,
    UN_DRAIN = 1'b1
  } un_state_t;

  pk_state_t            r_pk_state;
  pk_state_t            w_pk_state_nxt;
  logic [c_idx_w-1:0]   r_pk_idx;
  logic [c_idx_w-1:0]   w_pk_idx_nxt;
  logic [c_blk_w-1:0]   r_blk_data;

  un_state_t            r_un_state;
  un_state_t            w_un_state_nxt;
  logic [c_idx_w-1:0]   r_un_idx;
  logic [c_idx_w-1:0]   w_un_idx_nxt;
  logic [c_blk_w-1:0]   r_res;
  logic [WORD_W-1:0]    w_res_words [NWORDS];

  logic                 r_busy;
  logic                 w_pop;
  logic                 w_blk_hs;
  logic                 w_cap;
  logic                 w_push;
  logic                 w_res_done;

  // Split the captured result into words so the drain mux is a plain
  // array index rather than a computed part-select.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_res_word
    assign w_res_words[gi] = r_res[gi*WORD_W +: WORD_W];
  end

  // --------------------------------------------------------------------------
  // Next-state and combinational handshake outputs. The handshake outputs are
  // gated by reset so nothing is popped, pushed or accepted while in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pk_state_nxt = r_pk_state;
    w_pk_idx_nxt   = r_pk_idx;
    w_pop          = 1'b0;
    w_blk_hs       = 1'b0;
    w_un_state_nxt = r_un_state;
    w_un_idx_nxt   = r_un_idx;
    w_cap          = 1'b0;
    w_push         = 1'b0;
    w_res_done     = 1'b0;
    res_ready      = 1'b0;

    case (r_pk_state)
      PK_FILL: begin
        if (!in_empty && !rst_main_sync) begin
          w_pop        = 1'b1;
          w_pk_idx_nxt = r_pk_idx + c_idx_one;
          if (r_pk_idx == c_last_idx) begin
            w_pk_state_nxt = PK_HOLD;
            w_pk_idx_nxt   = '0;
          end
        end
      end
      PK_HOLD: begin
        if (blk_ready && !rst_main_sync) begin
          w_blk_hs       = 1'b1;
          w_pk_state_nxt = PK_FILL;
        end
      end
      default: w_pk_state_nxt = PK_FILL;
    endcase

    case (r_un_state)
      UN_IDLE: begin
        res_ready = !rst_main_sync;
        if (res_valid && !rst_main_sync) begin
          w_cap          = 1'b1;
          w_un_idx_nxt   = '0;
          w_un_state_nxt = UN_DRAIN;
        end
      end
      UN_DRAIN: begin
        if (!out_full && !rst_main_sync) begin
          w_push       = 1'b1;
          w_un_idx_nxt = r_un_idx + c_idx_one;
          if (r_un_idx == c_last_idx) begin
            w_res_done     = 1'b1;
            w_un_state_nxt = UN_IDLE;
            w_un_idx_nxt   = '0;
          end
        end
      end
      default: w_un_state_nxt = UN_IDLE;
    endcase

    in_rd_en  = w_pop;
    out_wr_en = w_push;
  end

  // --------------------------------------------------------------------------
  // State, datapath and counters. The counters are the output ports
  // themselves so there is exactly one register per count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      r_pk_state <= PK_FILL;
      r_pk_idx   <= '0;
      r_blk_data <= '0;
      r_un_state <= UN_IDLE;
      r_un_idx   <= '0;
      r_res      <= '0;
      r_busy     <= 1'b0;
      blk_count  <= 32'd0;
      res_count  <= 32'd0;
    end else begin
      r_pk_state <= w_pk_state_nxt;
      r_pk_idx   <= w_pk_idx_nxt;
      r_un_state <= w_un_state_nxt;
      r_un_idx   <= w_un_idx_nxt;

      for (int i = 0; i < NWORDS; i++) begin
        if (w_pop && (r_pk_idx == c_idx_w'(i))) begin
          r_blk_data[i*WORD_W +: WORD_W] <= in_dout;
        end
      end

      if (w_cap) begin
        r_res <= res_data;
      end

      if (w_blk_hs) begin
        blk_count <= blk_count + 32'd1;
      end

      if (w_res_done) begin
        res_count <= res_count + 32'd1;
      end

      // Registered from next-state values so busy lines up with the state
      // it describes instead of lagging it by a cycle.
      r_busy <= (w_pk_idx_nxt != '0) ||
                (w_pk_state_nxt == PK_HOLD) ||
                (w_un_state_nxt == UN_DRAIN);
    end
  end

  assign blk_valid = (r_pk_state == PK_HOLD);
  assign blk_data  = r_blk_data;
  assign out_din   = w_res_words[r_un_idx];
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_word_packer
// Description : Self-checking bench for aes_word_packer. An upstream FWFT
//               FIFO model feeds the pack side; expected blocks and expected
//               readout words are queued when stimulus is applied and
//               compared by a monitor when the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_word_packer;

  logic          clk_main_a0;
  logic          rst_main_sync;
  logic          in_empty;
  logic [31:0]   in_dout;
  logic          in_rd_en;
  logic          blk_valid;
  logic [127:0]  blk_data;
  logic          blk_ready;
  logic          res_valid;
  logic [127:0]  res_data;
  logic          res_ready;
  logic          out_full;
  logic          out_wr_en;
  logic [31:0]   out_din;
  logic [31:0]   blk_count;
  logic [31:0]   res_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_push   = 0;
  int n_blk    = 0;
  int n_valid_cyc = 0;

  // Upstream FIFO model; starve forces empty regardless of content.
  logic [31:0] fifo_mem [0:63];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        starve = 1'b0;
  logic        pop_s;

  logic [127:0] exp_blk_q [$];
  logic [31:0]  exp_word_q [$];
  logic [127:0] e_blk;
  logic [31:0]  e_word;

  assign in_empty = starve || (rd_ptr == wr_ptr);
  assign in_dout  = fifo_mem[rd_ptr[5:0]];

  aes_word_packer #(
    .WORD_W (32),
    .NWORDS (4)
  ) u_dut (
    .clk_main_a0   (clk_main_a0),
    .rst_main_sync (rst_main_sync),
    .in_empty      (in_empty),
    .in_dout       (in_dout),
    .in_rd_en      (in_rd_en),
    .blk_valid     (blk_valid),
    .blk_data      (blk_data),
    .blk_ready     (blk_ready),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .out_full      (out_full),
    .out_wr_en     (out_wr_en),
    .out_din       (out_din),
    .blk_count     (blk_count),
    .res_count     (res_count),
    .busy          (busy)
  );

  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // FIFO pop: decided by the pre-edge in_rd_en, applied just after the edge.
  always begin
    @(negedge clk_main_a0);
    pop_s = in_rd_en;
    @(posedge clk_main_a0);
    #1;
    if (pop_s) rd_ptr = rd_ptr + 1;
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk_main_a0) begin
    if (blk_valid === 1'b1) begin
      n_valid_cyc++;
      n_checks++;
      if (in_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL pop_in_hold: in_rd_en=%b required 0", in_rd_en);
      end
    end
    if (in_rd_en === 1'b1) begin
      n_pop++;
      n_checks++;
      if (in_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL pop_when_empty: in_empty=%b required 0", in_empty);
      end
    end
    if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
      n_blk++;
      n_checks++;
      if (exp_blk_q.size() == 0) begin
        n_fail++;
        $display("FAIL blk_unexpected: blk_data=%h with no block expected", blk_data);
      end else begin
        e_blk = exp_blk_q.pop_front();
        if (blk_data !== e_blk) begin
          n_fail++;
          $display("FAIL blk_data: got %h required %h", blk_data, e_blk);
        end
      end
    end
    if (out_wr_en === 1'b1) begin
      n_push++;
      n_checks++;
      if (out_full !== 1'b0 || res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL push_ctrl: out_full=%b res_ready=%b required 0/0", out_full, res_ready);
      end
      n_checks++;
      if (exp_word_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: out_din=%h with no word expected", out_din);
      end else begin
        e_word = exp_word_q.pop_front();
        if (out_din !== e_word) begin
          n_fail++;
          $display("FAIL out_din: got %h required %h", out_din, e_word);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic load_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    push_word(w0);
    push_word(w1);
    push_word(w2);
    push_word(w3);
    exp_blk_q.push_back({w3, w2, w1, w0});
  endtask

  // Returns one cycle after the capture edge, i.e. in the first drain cycle.
  task automatic send_result(input logic [127:0] d);
    int k;
    k = 0;
    while (res_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    n_checks++;
    if (res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL res_ready_timeout: res_ready=%b required 1", res_ready);
    end
    res_valid = 1'b1;
    res_data  = d;
    for (int i = 0; i < 4; i++) exp_word_q.push_back(d[i*32 +: 32]);
    step();
    res_valid = 1'b0;
  endtask

  task automatic wait_blk(input int target);
    int k;
    k = 0;
    while (n_blk < target && k < 100) begin
      step();
      k++;
    end
    n_checks++;
    if (n_blk < target) begin
      n_fail++;
      $display("FAIL blk_timeout: blocks=%0d required %0d", n_blk, target);
    end
  endtask

  task automatic wait_push(input int target);
    int k;
    k = 0;
    while (n_push < target && k < 100) begin
      step();
      k++;
    end
    n_checks++;
    if (n_push < target) begin
      n_fail++;
      $display("FAIL push_timeout: pushes=%0d required %0d", n_push, target);
    end
  endtask

  task automatic test_reset();
    rst_main_sync = 1'b1;
    repeat (3) step();
    @(negedge clk_main_a0);
    n_checks++;
    if ({in_rd_en, blk_valid, res_ready, out_wr_en, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd/bv/rr/wr/busy=%b required 00000",
               {in_rd_en, blk_valid, res_ready, out_wr_en, busy});
    end
    n_checks++;
    if (blk_data !== 128'd0 || out_din !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: blk_data=%h out_din=%h required 0", blk_data, out_din);
    end
    n_checks++;
    if (blk_count !== 32'd0 || res_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: blk=%h res=%h required 0", blk_count, res_count);
    end
    step();
    rst_main_sync = 1'b0;
    @(negedge clk_main_a0);
    n_checks++;
    if (res_ready !== 1'b1 || blk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: res_ready=%b blk_valid=%b required 1/0", res_ready, blk_valid);
    end
    step();
  endtask

  task automatic test_basic_pack();
    int v0;
    int b0;
    v0 = n_valid_cyc;
    b0 = n_blk;
    blk_ready = 1'b1;
    load_block(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    wait_blk(b0 + 1);
    n_checks++;
    if (blk_count !== 32'd1) begin
      n_fail++;
      $display("FAIL pack_count: blk_count=%0d required 1", blk_count);
    end
    n_checks++;
    if (n_valid_cyc - v0 != 1) begin
      n_fail++;
      $display("FAIL pack_valid_len: valid cycles=%0d required 1", n_valid_cyc - v0);
    end
    n_checks++;
    if (blk_data !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin
      n_fail++;
      $display("FAIL pack_layout: blk_data=%h", blk_data);
    end
  endtask

  task automatic test_starved_fill();
    int b0;
    int k;
    b0 = n_blk;
    blk_ready = 1'b0;
    load_block(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    k = 0;
    while (blk_valid !== 1'b1 && k < 40) begin
      step();
      starve = ~starve;
      k++;
    end
    starve = 1'b0;
    n_checks++;
    if (blk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_timeout: blk_valid=%b required 1", blk_valid);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_main_a0);
      n_checks++;
      if (blk_valid !== 1'b1 || blk_data !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d blk_valid=%b blk_data=%h", c, blk_valid, blk_data);
      end
    end
    step();
    blk_ready = 1'b1;
    wait_blk(b0 + 1);
    n_checks++;
    if (blk_count !== 32'd2) begin
      n_fail++;
      $display("FAIL starve_count: blk_count=%0d required 2", blk_count);
    end
  endtask

  task automatic test_basic_unpack();
    out_full = 1'b0;
    send_result(128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_main_a0);
      n_checks++;
      if (out_wr_en !== 1'b1 || res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL unpack_seq: cycle %0d out_wr_en=%b res_ready=%b required 1/0",
                 c, out_wr_en, res_ready);
      end
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (res_ready !== 1'b1 || out_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL unpack_done: res_ready=%b out_wr_en=%b required 1/0", res_ready, out_wr_en);
    end
    n_checks++;
    if (res_count !== 32'd1) begin
      n_fail++;
      $display("FAIL unpack_count: res_count=%0d required 1", res_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = n_push;
    send_result(128'h4040_4040_3030_3030_2020_2020_1010_1010);
    step();
    step();
    out_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_main_a0);
      n_checks++;
      if (out_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall: cycle %0d out_wr_en=%b required 0", c, out_wr_en);
      end
      step();
    end
    out_full = 1'b0;
    wait_push(p0 + 4);
    repeat (3) step();
    n_checks++;
    if (n_push - p0 != 4) begin
      n_fail++;
      $display("FAIL bp_push_total: pushes=%0d required 4", n_push - p0);
    end
    n_checks++;
    if (res_count !== 32'd2) begin
      n_fail++;
      $display("FAIL bp_count: res_count=%0d required 2", res_count);
    end
  endtask

  task automatic test_concurrent_wrap();
    int b0;
    int p0;
    b0 = n_blk;
    p0 = n_push;
    force u_dut.blk_count = 32'hFFFF_FFFF;
    step();
    release u_dut.blk_count;
    step();
    load_block(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
    send_result(128'h0D0D_0D0D_0C0C_0C0C_0B0B_0B0B_0A0A_0A0A);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_busy: busy=%b required 1", busy);
    end
    wait_blk(b0 + 1);
    wait_push(p0 + 4);
    step();
    n_checks++;
    if (blk_count !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_count: blk_count=%h required 00000000", blk_count);
    end
    n_checks++;
    if (res_count !== 32'd3) begin
      n_fail++;
      $display("FAIL conc_res_count: res_count=%0d required 3", res_count);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    int p0;
    int q0;
    p0 = n_push;
    q0 = n_pop;
    out_full = 1'b1;
    push_word(32'hBAD0_0000);
    push_word(32'hBAD0_0001);
    send_result(128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_1234_5678);
    out_full = 1'b0;
    step();
    out_full = 1'b1;
    n_checks++;
    if (n_push - p0 != 1 || n_pop - q0 != 2) begin
      n_fail++;
      $display("FAIL mid_setup: pushes=%0d pops=%0d required 1/2", n_push - p0, n_pop - q0);
    end
    rst_main_sync = 1'b1;
    exp_word_q.delete();
    step();
    @(negedge clk_main_a0);
    n_checks++;
    if ({in_rd_en, blk_valid, res_ready, out_wr_en, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: rd/bv/rr/wr/busy=%b required 00000",
               {in_rd_en, blk_valid, res_ready, out_wr_en, busy});
    end
    n_checks++;
    if (blk_data !== 128'd0 || out_din !== 32'd0 || blk_count !== 32'd0 || res_count !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: blk_data=%h out_din=%h blk=%h res=%h required 0",
               blk_data, out_din, blk_count, res_count);
    end
    step();
    rst_main_sync = 1'b0;
    out_full = 1'b0;
    b0 = n_blk;
    load_block(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    wait_blk(b0 + 1);
    n_checks++;
    if (blk_count !== 32'd1) begin
      n_fail++;
      $display("FAIL mid_fresh_count: blk_count=%0d required 1", blk_count);
    end
  endtask

  initial begin
    rst_main_sync = 1'b1;
    blk_ready     = 1'b1;
    res_valid     = 1'b0;
    res_data      = 128'd0;
    out_full      = 1'b0;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 32'd0;

    test_reset();
    test_basic_pack();
    test_starved_fill();
    test_basic_unpack();
    test_backpressure();
    test_concurrent_wrap();
    test_reset_mid();

    repeat (3) step();
    n_checks++;
    if (exp_blk_q.size() != 0 || exp_word_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: blocks=%0d words=%0d required 0/0",
               exp_blk_q.size(), exp_word_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
